// File: rtl/sram_ctrl_pkg.sv
// sram_pkg: shared widths, mask encoding, pipeline entry types and FSM
// state encoding for the ZBT SRAM controller.
package sram_pkg;
    localparam int ADDR_W_DEF = 18;
    localparam int DATA_W_DEF = 32;
    localparam int MASK_W     = DATA_W_DEF / 8;

    // An all-zero byte mask on the request port means "read"
    localparam logic [MASK_W-1:0] SRAM_MASK_READ = '0;

    // Address-phase entry (stage A): everything the chip needs on its address pins
    typedef struct packed {
        logic                  valid;
        logic                  is_write;
        logic [MASK_W-1:0]     mask;
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] data;
    } pipe_entry_t;

    // Data-phase entry carried through D1/D2; the address is consumed in stage A
    typedef struct packed {
        logic                  valid;
        logic                  is_write;
        logic [DATA_W_DEF-1:0] data;
    } data_entry_t;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } sram_state_e;
endpackage

// File: rtl/sram_ctrl_if.sv
// sram_ctrl_if: arbiter request port plus external ZBT chip pins.
// slave = controller side, master = arbiter/chip side.
interface sram_ctrl_if #(
    parameter int ADDR_W = sram_pkg::ADDR_W_DEF,
    parameter int DATA_W = sram_pkg::DATA_W_DEF
);
    localparam int MASK_W = DATA_W / 8;

    logic              sram_addr_valid;
    logic              sram_ready;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_data_in;
    logic [MASK_W-1:0] sram_write_mask;
    logic [DATA_W-1:0] sram_data_out;
    logic              sram_data_out_valid;

    logic              ext_ce_n;
    logic              ext_we_n;
    logic [MASK_W-1:0] ext_bw_n;
    logic [ADDR_W-1:0] ext_addr;
    logic [DATA_W-1:0] ext_dq_o;
    logic              ext_dq_oe;
    logic [DATA_W-1:0] ext_dq_i;

    modport slave (
        input  sram_addr_valid, sram_addr, sram_data_in, sram_write_mask, ext_dq_i,
        output sram_ready, sram_data_out, sram_data_out_valid,
        output ext_ce_n, ext_we_n, ext_bw_n, ext_addr, ext_dq_o, ext_dq_oe
    );

    modport master (
        output sram_addr_valid, sram_addr, sram_data_in, sram_write_mask, ext_dq_i,
        input  sram_ready, sram_data_out, sram_data_out_valid,
        input  ext_ce_n, ext_we_n, ext_bw_n, ext_addr, ext_dq_o, ext_dq_oe
    );
endinterface

// File: rtl/sram_ctrl_pipe.sv
// sram_ctrl_pipe: fixed-depth shift register of pipeline entries with
// asynchronous clear, so a reset drops every operation in flight.
module sram_ctrl_pipe #(
    parameter type entry_t = logic,
    parameter int  STAGES  = 2
) (
    input  logic   clk,
    input  logic   rst_n,
    input  entry_t din,
    output entry_t dout
);
    entry_t stage_d [STAGES];
    entry_t stage_q [STAGES];

    // Each stage takes the contents of the one behind it
    always_comb begin
        stage_d[0] = din;
        for (int i = 1; i < STAGES; i++) stage_d[i] = stage_q[i-1];
    end

    // Shift every cycle; clear all entries (including valid bits) on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign dout = stage_q[STAGES-1];
endmodule

// File: rtl/sram_ctrl.sv
// sram_ctrl: request port to pipelined ZBT SRAM. Stage A drives the address
// phase, D1/D2 delay the op to the chip's data phase, stage R returns reads.
// Read latency is fixed at 4 cycles; reads and writes mix with no bubbles.
// The pipeline entries use the package widths, so ADDR_W/DATA_W overrides
// must be matched by the package defaults.
module sram_ctrl
    import sram_pkg::*;
#(
    parameter int INIT_CYCLES = 16,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF
) (
    input  logic       sram_clock,
    input  logic       reset,
    sram_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(INIT_CYCLES + 2);

    sram_state_e      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ready_q;

    // Post-reset init countdown; ready rises on the INIT_CYCLES-th edge and stays
    always_ff @(posedge sram_clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_INIT;
            cnt_q   <= CNT_W'(INIT_CYCLES);
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    if (cnt_q <= CNT_W'(1)) begin
                        state_q <= ST_RUN;
                        cnt_q   <= '0;
                        ready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: ready_q <= 1'b1;
            endcase
        end
    end

    assign bus.sram_ready = ready_q;

    // ---------------- Stage A: address phase ----------------
    pipe_entry_t a_d, a_q;

    // Capture the accepted request; no accept means a bubble (all-zero entry)
    always_comb begin
        a_d = '0;
        if (bus.sram_addr_valid && ready_q) begin
            a_d.valid    = 1'b1;
            a_d.is_write = (bus.sram_write_mask != SRAM_MASK_READ);
            a_d.mask     = bus.sram_write_mask;
            a_d.addr     = bus.sram_addr;
            a_d.data     = bus.sram_data_in;
        end
    end

    // Address-phase register
    always_ff @(posedge sram_clock or negedge reset) begin
        if (!reset) a_q <= '0;
        else        a_q <= a_d;
    end

    // A zeroed entry yields exactly the idle pin values
    assign bus.ext_ce_n = ~a_q.valid;
    assign bus.ext_we_n = ~(a_q.valid & a_q.is_write);
    assign bus.ext_bw_n = ~a_q.mask;
    assign bus.ext_addr = ADDR_W'(a_q.addr);

    // ---------------- D1 -> D2: data-phase delay ----------------
    data_entry_t a_data, d2;
    assign a_data = '{valid: a_q.valid, is_write: a_q.is_write, data: a_q.data};

    sram_ctrl_pipe #(
        .entry_t (data_entry_t),
        .STAGES  (2)
    ) u_pipe (
        .clk   (sram_clock),
        .rst_n (reset),
        .din   (a_data),
        .dout  (d2)
    );

    // Write data only drives the pad during its own D2 cycle
    assign bus.ext_dq_oe = d2.valid & d2.is_write;
    assign bus.ext_dq_o  = (d2.valid && d2.is_write) ? d2.data : '0;

    // ---------------- Stage R: read return ----------------
    logic              rd_vld_d, rd_vld_q;
    logic [DATA_W-1:0] rd_data_d, rd_data_q;

    // Sample the chip at the end of a read's D2 cycle; hold data otherwise
    always_comb begin
        rd_vld_d  = d2.valid & ~d2.is_write;
        rd_data_d = rd_vld_d ? bus.ext_dq_i : rd_data_q;
    end

    // Response register
    always_ff @(posedge sram_clock or negedge reset) begin
        if (!reset) begin
            rd_vld_q  <= 1'b0;
            rd_data_q <= '0;
        end else begin
            rd_vld_q  <= rd_vld_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign bus.sram_data_out_valid = rd_vld_q;
    assign bus.sram_data_out       = rd_data_q;
endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: ZBT chip model plus a cycle-level reference of the
// controller's pin timing and read results, with directed and random traffic.
module tb_sram_ctrl;
    import sram_pkg::*;

    localparam int AW   = 18;
    localparam int DW   = 32;
    localparam int INIT = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sram_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    sram_ctrl #(.INIT_CYCLES(INIT), .ADDR_W(AW), .DATA_W(DW)) dut (
        .sram_clock (clk),
        .reset      (rst_n),
        .bus        (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h, expected %h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] pre(input int a);
        return 32'hC0DE0000 + a;
    endfunction

    // ---------------- chip model: address phase, data two cycles later ----------------
    typedef struct packed {
        logic          en;
        logic          wr;
        logic [3:0]    bw_n;
        logic [AW-1:0] addr;
    } ph_t;

    logic [31:0] chip_mem [0:(1<<AW)-1];
    logic [31:0] ref_mem  [0:(1<<AW)-1];
    ph_t cp1, cp2;

    always @(posedge clk) begin
        cp1 <= '{en: !bus.ext_ce_n, wr: !bus.ext_we_n, bw_n: bus.ext_bw_n, addr: bus.ext_addr};
        cp2 <= cp1;
        if (cp2.en && cp2.wr && bus.ext_dq_oe)
            for (int b = 0; b < 4; b++)
                if (!cp2.bw_n[b]) chip_mem[cp2.addr][8*b +: 8] <= bus.ext_dq_o[8*b +: 8];
    end

    assign bus.ext_dq_i = (cp2.en && !cp2.wr) ? chip_mem[cp2.addr] : 32'h0;

    // ---------------- reference: what each accepted request must produce ----------------
    typedef struct packed {
        logic          acc;
        logic          wr;
        logic [3:0]    mask;
        logic [AW-1:0] addr;
        logic [31:0]   data;   // write data, or expected read data
    } rec_t;

    rec_t        hist [0:4];
    logic [31:0] last_rd;
    logic [3:0]  exp_bw;
    int          cyc = 0;

    logic [31:0] rsp_q [$];
    int          rsp_cyc [$];
    logic [31:0] oe_q [$];
    logic [3:0]  bw_q [$];

    task automatic clear_q();
        rsp_q.delete(); rsp_cyc.delete(); oe_q.delete(); bw_q.delete();
    endtask

    // Compare process: hist[k] is the request seen k negedges ago
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                for (int i = 0; i < 5; i++) hist[i] = '0;
                last_rd = '0;
                chk("rst_ready", bus.sram_ready, 0);
                chk("rst_ce_n", bus.ext_ce_n, 1);
                chk("rst_oe", bus.ext_dq_oe, 0);
                chk("rst_dvld", bus.sram_data_out_valid, 0);
                chk("rst_dout", bus.sram_data_out, 0);
            end else begin
                for (int i = 4; i > 0; i--) hist[i] = hist[i-1];
                chk("ce_n", bus.ext_ce_n, !hist[1].acc);
                if (hist[1].acc) begin
                    exp_bw = ~hist[1].mask;
                    chk("we_n", bus.ext_we_n, !hist[1].wr);
                    chk("bw_n", bus.ext_bw_n, exp_bw);
                    chk("addr", bus.ext_addr, hist[1].addr);
                end
                chk("dq_oe", bus.ext_dq_oe, hist[3].acc && hist[3].wr);
                if (hist[3].acc && hist[3].wr) chk("dq_o", bus.ext_dq_o, hist[3].data);
                chk("rd_vld", bus.sram_data_out_valid, hist[4].acc && !hist[4].wr);
                if (hist[4].acc && !hist[4].wr) last_rd = hist[4].data;
                chk("rd_data", bus.sram_data_out, last_rd);

                hist[0] = '0;
                if (bus.sram_addr_valid && bus.sram_ready) begin
                    hist[0].acc  = 1'b1;
                    hist[0].wr   = (bus.sram_write_mask != 4'b0000);
                    hist[0].mask = bus.sram_write_mask;
                    hist[0].addr = bus.sram_addr;
                    if (hist[0].wr) begin
                        hist[0].data = bus.sram_data_in;
                        for (int b = 0; b < 4; b++)
                            if (bus.sram_write_mask[b])
                                ref_mem[bus.sram_addr][8*b +: 8] = bus.sram_data_in[8*b +: 8];
                    end else begin
                        hist[0].data = ref_mem[bus.sram_addr];
                    end
                end
            end
            if (bus.sram_data_out_valid) begin rsp_q.push_back(bus.sram_data_out); rsp_cyc.push_back(cyc); end
            if (bus.ext_dq_oe) oe_q.push_back(bus.ext_dq_o);
            if (!bus.ext_ce_n) bw_q.push_back(bus.ext_bw_n);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drv(input bit v, input logic [3:0] m, input logic [AW-1:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        bus.sram_addr_valid = v;
        bus.sram_write_mask = m;
        bus.sram_addr       = a;
        bus.sram_data_in    = d;
    endtask

    task automatic idle(input int n);
        repeat (n) drv(0, 4'h0, '0, 32'h0);
    endtask

    // Release reset and measure the cycles until sram_ready rises
    task automatic init_wait();
        int n, ce_seen;
        n = 0; ce_seen = 0;
        @(posedge clk); #1 rst_n = 1'b1;
        while (n < 100) begin
            @(posedge clk); n++;
            @(negedge clk);
            if (bus.sram_ready) break;
            if (!bus.ext_ce_n) ce_seen++;
        end
        chk("init_len", n, INIT);
        chk("ce_during_init", ce_seen, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [AW-1:0] wa;

    initial begin
        for (int a = 0; a < (1 << AW); a++) begin
            chip_mem[a] = pre(a);
            ref_mem[a]  = pre(a);
        end
        bus.sram_addr_valid = 0; bus.sram_write_mask = 0; bus.sram_addr = 0; bus.sram_data_in = 0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst0_ready", bus.sram_ready, 0);
        chk("rst0_we_n", bus.ext_we_n, 1);
        chk("rst0_bw_n", bus.ext_bw_n, 4'hF);
        chk("rst0_addr", bus.ext_addr, 0);
        chk("rst0_dq_o", bus.ext_dq_o, 0);

        // Init gating with valid held high
        bus.sram_addr_valid = 1; bus.sram_addr = 5;
        init_wait();
        idle(8);
        clear_q();

        // Write then read-after-write, same address
        drv(1, 4'hF, 18'h00010, 32'hDEADBEEF);
        drv(1, 4'h0, 18'h00010, 32'h0);
        idle(8);
        chk("raw_oe_cnt", oe_q.size(), 1);
        chk("raw_dq_o", oe_q[0], 32'hDEADBEEF);
        chk("raw_rsp_cnt", rsp_q.size(), 1);
        chk("raw_rsp", rsp_q[0], 32'hDEADBEEF);
        clear_q();

        // Partial byte write over a full word
        drv(1, 4'hF, 18'h00020, 32'hAAAAAAAA);
        drv(1, 4'b0101, 18'h00020, 32'h11223344);
        drv(1, 4'h0, 18'h00020, 32'h0);
        idle(8);
        chk("pw_ce_cnt", bw_q.size(), 3);
        chk("pw_bw_n", bw_q[1], 4'b1010);
        chk("pw_rsp", rsp_q[0], 32'hAA22AA44);
        clear_q();

        // Eight back-to-back reads of preloaded words
        for (int i = 0; i < 8; i++) drv(1, 4'h0, AW'(i), 32'h0);
        idle(8);
        chk("burst_cnt", rsp_q.size(), 8);
        for (int i = 0; i < 8; i++) chk("burst_data", rsp_q[i], 32'hC0DE0000 + i);
        chk("burst_span", rsp_cyc[7] - rsp_cyc[0], 7);
        clear_q();

        // Alternating write/read, 64 ops
        wa = '0;
        for (int i = 0; i < 64; i++) begin
            if (i % 2 == 0) begin
                wa = AW'(18'h100 + $urandom_range(0, 15));
                drv(1, 4'($urandom_range(1, 15)), wa, $urandom);
            end else begin
                drv(1, 4'h0, ($urandom_range(0, 1) != 0) ? wa : AW'(18'h100 + $urandom_range(0, 15)), 32'h0);
            end
        end
        idle(8);
        chk("alt_ce_cnt", bw_q.size(), 64);
        chk("alt_oe_cnt", oe_q.size(), 32);
        chk("alt_rsp_cnt", rsp_q.size(), 32);
        clear_q();

        // Random mix with bubbles
        for (int i = 0; i < 300; i++) begin
            drv($urandom_range(0, 3) != 0,
                ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom_range(0, 15)),
                AW'(18'h200 + $urandom_range(0, 15)), $urandom);
        end
        idle(8);
        clear_q();

        // Reset with three reads in flight
        drv(1, 4'h0, 18'h1, 32'h0);
        drv(1, 4'h0, 18'h2, 32'h0);
        drv(1, 4'h0, 18'h3, 32'h0);
        @(posedge clk); #3;
        bus.sram_addr_valid = 0;
        rst_n = 1'b0;
        #1;
        chk("arst_ce_n", bus.ext_ce_n, 1);
        chk("arst_ready", bus.sram_ready, 0);
        chk("arst_dout", bus.sram_data_out, 0);
        chk("arst_oe", bus.ext_dq_oe, 0);
        chk("arst_dvld", bus.sram_data_out_valid, 0);
        repeat (4) @(posedge clk);
        init_wait();
        idle(6);
        chk("arst_no_rsp", rsp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
